// File: rtl/tw_pkg.sv
// Shared encodings and widths for the horizontal twiddle-load interface.
// The TW ROM side imports the same ROM1_w encodings.
package tw_pkg;

    localparam int P_WIDTH         = 128;
    localparam int horizontal_DW   = 64;
    localparam int SEG1            = 64;
    localparam int SEG2            = 128;
    localparam int init_store_data = 4;
    localparam int IDX_WIDTH       = 2;

    typedef enum logic [1:0] {
        TW_W_IDLE = 2'd0,
        TW_W_HI   = 2'd1,
        TW_W_LO   = 2'd2
    } tw_w_e;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ARMED   = 2'd1,
        SEND_HI = 2'd2,
        SEND_LO = 2'd3
    } tw_state_e;

endpackage

// File: rtl/tw_buf4.sv
// Twiddle word buffer: one write port, one combinational read port that
// returns either the upper or the lower half of the addressed word.
module tw_buf4
    import tw_pkg::*;
#(
    parameter int DEPTH = init_store_data,
    parameter int AW    = IDX_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [P_WIDTH-1:0]       i_wr_data,
    input  logic [AW-1:0]            i_rd_addr,
    input  logic                     i_rd_hi,
    output logic [horizontal_DW-1:0] o_rd_half
);

    // Contents are intentionally not reset; they are don't-care until refilled.
    logic [P_WIDTH-1:0] r_mem [DEPTH];
    logic [P_WIDTH-1:0] w_word;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_word    = r_mem[i_rd_addr];
    assign o_rd_half = i_rd_hi ? w_word[SEG2-1:SEG1] : w_word[SEG1-1:0];

endmodule

// File: rtl/tw_horizontal_tx.sv
// Horizontal twiddle-load transmitter: buffers init_store_data words, then
// sends all upper halves (ROM1_w=1) followed by all lower halves (ROM1_w=2).
//
// state   | meaning
// FILL    | accepting tf_in words into the buffer
// ARMED   | buffer full, waiting for send_en
// SEND_HI | upper-half beat of buf[rd_idx] on the output
// SEND_LO | lower-half beat of buf[rd_idx] on the output
module tw_horizontal_tx
    import tw_pkg::*;
(
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [P_WIDTH-1:0]       tf_in,
    input  logic                     tf_in_valid,
    output logic                     tf_in_ready,
    input  logic                     send_en,
    output logic [horizontal_DW-1:0] horizontal_tf_out,
    output logic [1:0]               ROM1_w,
    output logic                     busy,
    output logic                     done
);

    tw_state_e                r_state;
    logic [IDX_WIDTH-1:0]     r_wr_idx;
    logic [IDX_WIDTH-1:0]     r_rd_idx;
    logic [1:0]               r_rom1_w;
    logic [horizontal_DW-1:0] r_tf_out;
    logic                     r_done;

    logic                     w_accept;
    logic                     w_wr_last;
    logic                     w_rd_last;
    logic                     w_rd_hi;
    logic [IDX_WIDTH-1:0]     w_rd_addr;
    logic [horizontal_DW-1:0] w_rd_half;

    assign w_accept  = (r_state == FILL) && tf_in_valid && !clear && !rst;
    assign w_wr_last = (r_wr_idx == IDX_WIDTH'(init_store_data - 1));
    assign w_rd_last = (r_rd_idx == IDX_WIDTH'(init_store_data - 1));

    // The buffer is read one beat ahead so each beat lands in a register.
    assign w_rd_hi   = (r_state == ARMED) || ((r_state == SEND_HI) && !w_rd_last);
    assign w_rd_addr = (((r_state == SEND_HI) || (r_state == SEND_LO)) && !w_rd_last)
                       ? r_rd_idx + IDX_WIDTH'(1) : '0;

    tw_buf4 u_buf (
        .i_clk     (CLK),
        .i_we      (w_accept),
        .i_wr_addr (r_wr_idx),
        .i_wr_data (tf_in),
        .i_rd_addr (w_rd_addr),
        .i_rd_hi   (w_rd_hi),
        .o_rd_half (w_rd_half)
    );

    always_ff @(posedge CLK) begin
        if (rst || clear) begin
            r_state  <= FILL;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_rom1_w <= TW_W_IDLE;
            r_tf_out <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_wr_idx <= r_wr_idx + IDX_WIDTH'(1);
                        if (w_wr_last) begin
                            r_state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (send_en) begin
                        r_state  <= SEND_HI;
                        r_rd_idx <= '0;
                        r_rom1_w <= TW_W_HI;
                        r_tf_out <= w_rd_half;
                    end
                end
                SEND_HI: begin
                    // send_en is no longer looked at: a burst cannot pause.
                    r_rd_idx <= r_rd_idx + IDX_WIDTH'(1);
                    r_tf_out <= w_rd_half;
                    if (w_rd_last) begin
                        r_state  <= SEND_LO;
                        r_rom1_w <= TW_W_LO;
                    end
                end
                SEND_LO: begin
                    r_rd_idx <= r_rd_idx + IDX_WIDTH'(1);
                    if (w_rd_last) begin
                        r_state  <= FILL;
                        r_rom1_w <= TW_W_IDLE;
                        r_tf_out <= '0;
                        r_done   <= 1'b1;
                    end else begin
                        r_tf_out <= w_rd_half;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign tf_in_ready       = (r_state == FILL);
    assign busy              = (r_state != FILL);
    assign ROM1_w            = r_rom1_w;
    assign horizontal_tf_out = r_tf_out;
    assign done              = r_done;

    a_no_rom1_w3: assert property (@(posedge CLK) disable iff (rst) ROM1_w != 2'd3);

endmodule

// File: tb/tb_tw_horizontal_tx.sv
// Scoreboard bench for tw_horizontal_tx: stimulus pushes expected beats,
// a negedge monitor pops and compares them, and a receiver model rebuilds words.
module tb_tw_horizontal_tx;

    logic         CLK = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic [127:0] tf_in = '0;
    logic         tf_in_valid = 1'b0;
    logic         tf_in_ready;
    logic         send_en = 1'b0;
    logic [63:0]  horizontal_tf_out;
    logic [1:0]   ROM1_w;
    logic         busy;
    logic         done;

    tw_horizontal_tx dut (
        .CLK               (CLK),
        .rst               (rst),
        .clear             (clear),
        .tf_in             (tf_in),
        .tf_in_valid       (tf_in_valid),
        .tf_in_ready       (tf_in_ready),
        .send_en           (send_en),
        .horizontal_tf_out (horizontal_tf_out),
        .ROM1_w            (ROM1_w),
        .busy              (busy),
        .done              (done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  w;
        logic [63:0] d;
        logic        dn;
    } beat_t;

    beat_t        sb[$];
    logic [127:0] m_words [4];
    logic [127:0] rx [4];
    int           rx_hi = 0;
    int           rx_lo = 0;
    int           n_vec = 0;
    int           n_err = 0;
    bit           mon_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected burst: every upper half in order, every lower half in order, then done.
    function automatic void push_burst();
        for (int i = 0; i < 4; i++) sb.push_back('{w: 2'd1, d: m_words[i][127:64], dn: 1'b0});
        for (int i = 0; i < 4; i++) sb.push_back('{w: 2'd2, d: m_words[i][63:0], dn: 1'b0});
        sb.push_back('{w: 2'd0, d: 64'd0, dn: 1'b1});
    endfunction

    always @(negedge CLK) begin
        beat_t e;
        if (mon_en) begin
            if (ROM1_w !== 2'd0 || done !== 1'b0) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: ROM1_w=%0d out=%0h done=%0b, nothing expected", ROM1_w, horizontal_tf_out, done);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {ROM1_w, horizontal_tf_out, done}, {e.w, e.d, e.dn});
                end
            end
            if (ROM1_w == 2'd1) begin
                rx[rx_hi % 4][127:64] = horizontal_tf_out;
                rx_hi++;
            end else if (ROM1_w == 2'd2) begin
                rx[rx_lo % 4][63:0] = horizontal_tf_out;
                rx_lo++;
            end else begin
                rx_hi = 0;
                rx_lo = 0;
            end
        end
    end

    // Entry and exit: just after a rising edge.
    task automatic fill(input logic [127:0] w [4], input int gapmode);
        int g;
        for (int i = 0; i < 4; i++) begin
            g = (gapmode == 1) ? 1 : ((gapmode == 2) ? int'($urandom_range(2, 0)) : 0);
            for (int k = 0; k < g; k++) begin
                tf_in_valid = 1'b0;
                tf_in = rnd128();
                @(posedge CLK); #1;
            end
            tf_in_valid = 1'b1;
            tf_in = w[i];
            m_words[i] = w[i];
            @(negedge CLK);
            chk("fill_ready", tf_in_ready, 1);
            @(posedge CLK); #1;
        end
        tf_in_valid = 1'b0;
    endtask

    // abort_kind: 0 none, 1 clear, 2 rst, asserted during beat cycle abort_at.
    task automatic run_burst(input int hold, input int drop_at, input bit junk,
                             input int abort_at, input int abort_kind);
        int n;
        bit got;
        @(negedge CLK);
        chk("armed_ready", tf_in_ready, 0);
        chk("armed_busy", busy, 1);
        for (int k = 0; k < hold; k++) begin
            send_en = 1'b0;
            if (junk) begin
                tf_in_valid = 1'b1;
                tf_in = rnd128();
            end
            @(negedge CLK);
            chk("hold_w", ROM1_w, 0);
            chk("hold_busy", busy, 1);
        end
        tf_in_valid = 1'b0;
        send_en = 1'b1;
        push_burst();
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge CLK); #1;
            n++;
            if (n == drop_at) send_en = 1'b0;
            if (abort_kind != 0 && n == abort_at + 1) begin
                clear = 1'b0;
                rst = 1'b0;
                send_en = 1'b0;
                sb.delete();
            end
            if (abort_kind != 0 && n == abort_at) begin
                if (abort_kind == 1) clear = 1'b1;
                else rst = 1'b1;
            end
            @(negedge CLK);
            if (n == 1) chk("first_beat_latency", ROM1_w, 1);
            if (abort_kind != 0 && n == abort_at + 1) begin
                chk("abort_w", ROM1_w, 0);
                chk("abort_out", horizontal_tf_out, 0);
                chk("abort_done", done, 0);
                chk("abort_busy", busy, 0);
                chk("abort_ready", tf_in_ready, 1);
                @(posedge CLK); #1;
                return;
            end
            if (done === 1'b1) got = 1'b1;
        end
        chk("burst_len", n, 9);
        chk("done_ready", tf_in_ready, 1);
        chk("done_busy", busy, 0);
        @(posedge CLK); #1;
        send_en = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] w [4];
        logic [127:0] last_w [4];

        repeat (2) @(posedge CLK);
        #1 rst = 1'b0;
        @(negedge CLK);
        chk("rst_w", ROM1_w, 0);
        chk("rst_out", horizontal_tf_out, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tf_in_ready, 1);
        mon_en = 1'b1;
        @(posedge CLK); #1;

        w[0] = 128'h0000000000000001_0000000000000001;
        w[1] = 128'hfffdffff00000003_5b11501d07d1bfa5;
        w[2] = 128'hfff7ffff00000001_ffeffffefffffff1;
        w[3] = 128'hffeffffefffffff1_52ca810d84ba33e7;
        send_en = 1'b1;
        fill(w, 0);
        run_burst(0, 0, 1'b0, 0, 0);

        for (int i = 0; i < 4; i++) w[i] = rnd128();
        fill(w, 1);
        run_burst(10, 3, 1'b1, 0, 0);

        for (int i = 0; i < 4; i++) w[i] = rnd128();
        fill(w, 0);
        run_burst(2, 0, 1'b0, 3, 1);
        for (int i = 0; i < 4; i++) w[i] = rnd128();
        fill(w, 2);
        run_burst(0, 0, 1'b0, 0, 0);

        for (int i = 0; i < 2; i++) begin
            tf_in_valid = 1'b1;
            tf_in = rnd128();
            @(posedge CLK); #1;
        end
        tf_in = rnd128();
        clear = 1'b1;
        @(posedge CLK); #1;
        clear = 1'b0;
        tf_in_valid = 1'b0;
        @(negedge CLK);
        chk("clear_fill_ready", tf_in_ready, 1);
        chk("clear_fill_busy", busy, 0);
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++) w[i] = rnd128();
        fill(w, 0);
        run_burst(1, 5, 1'b1, 0, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) w[i] = rnd128();
            fill(w, 2);
            run_burst(int'($urandom_range(4, 0)), int'($urandom_range(8, 1)), 1'b1, 0, 0);
        end

        for (int i = 0; i < 4; i++) w[i] = rnd128();
        fill(w, 0);
        run_burst(0, 0, 1'b0, 6, 2);

        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) w[i] = rnd128();
            for (int i = 0; i < 4; i++) last_w[i] = w[i];
            fill(w, 0);
            run_burst(0, 0, 1'b0, 0, 0);
        end
        for (int i = 0; i < 4; i++) chk("rx_entry", rx[i], last_w[i]);

        repeat (5) @(posedge CLK);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
